// File: rtl/alu_operand_sequencer_if.sv
// Switch-bank/ALU bus for the operand sequencer: byte entry, ALU operands/result, display captures.
// slave = sequencer side, master = switches + ALU + display side.
interface alu_operand_sequencer_if #(
    parameter int DATA_W  = 32,
    parameter int CHUNK_W = 8
);
    logic [CHUNK_W-1:0] Din;
    logic               Load;
    logic [2:0]         Op;
    logic               Clear;
    logic [DATA_W-1:0]  AA;
    logic [DATA_W-1:0]  BB;
    logic [2:0]         ALU_OP;
    logic [DATA_W-1:0]  F;
    logic               ZF;
    logic               OF;
    logic [DATA_W-1:0]  Result;
    logic               ZF_Q;
    logic               OF_Q;
    logic               Done;
    logic [2:0]         State;

    modport master (
        output Din, Load, Op, Clear, F, ZF, OF,
        input  AA, BB, ALU_OP, Result, ZF_Q, OF_Q, Done, State
    );

    modport slave (
        input  Din, Load, Op, Clear, F, ZF, OF,
        output AA, BB, ALU_OP, Result, ZF_Q, OF_Q, Done, State
    );
endinterface

// File: rtl/alu_operand_sequencer.sv
// Assembles A/B MSB-byte-first from Load strobes, holds them one settle cycle, captures F/ZF/OF.
// Latency: last B strobe at edge N -> Done/Result valid after N+2; Load ignored in EXEC/CAPTURE, no backpressure.
module alu_operand_sequencer #(
    parameter int DATA_W  = 32,
    parameter int CHUNK_W = 8
) (
    input logic CLK,
    input logic RST_N,
    alu_operand_sequencer_if.slave bus
);
    localparam int NCHUNK = DATA_W / CHUNK_W;
    localparam int CNT_W  = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NCHUNK - 1);

    typedef enum logic [2:0] {
        LOAD_A  = 3'd0,
        LOAD_B  = 3'd1,
        EXEC    = 3'd2,
        CAPTURE = 3'd3,
        SHOW    = 3'd4
    } state_t;

    state_t             state_q, state_d;
    logic [DATA_W-1:0]  aa_q, aa_d;
    logic [DATA_W-1:0]  bb_q, bb_d;
    logic [DATA_W-1:0]  res_q, res_d;
    logic [2:0]         op_q, op_d;
    logic               zf_q, zf_d;
    logic               of_q, of_d;
    logic               done_q, done_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [DATA_W-1:0]  din_ext;

    assign din_ext = DATA_W'(bus.Din);

    always_comb begin
        state_d = state_q;
        aa_d    = aa_q;
        bb_d    = bb_q;
        res_d   = res_q;
        op_d    = op_q;
        zf_d    = zf_q;
        of_d    = of_q;
        done_d  = done_q;
        cnt_d   = cnt_q;

        // Clear overrides everything, including a coincident Load byte.
        if (bus.Clear) begin
            state_d = LOAD_A;
            aa_d    = '0;
            bb_d    = '0;
            res_d   = '0;
            op_d    = '0;
            zf_d    = 1'b0;
            of_d    = 1'b0;
            done_d  = 1'b0;
            cnt_d   = '0;
        end else begin
            case (state_q)
                LOAD_A: begin
                    if (bus.Load) begin
                        aa_d = (aa_q << CHUNK_W) | din_ext;
                        if (cnt_q == LAST_CNT) begin
                            cnt_d   = '0;
                            state_d = LOAD_B;
                        end else begin
                            cnt_d = cnt_q + CNT_W'(1);
                        end
                    end
                end
                LOAD_B: begin
                    if (bus.Load) begin
                        bb_d = (bb_q << CHUNK_W) | din_ext;
                        if (cnt_q == LAST_CNT) begin
                            cnt_d   = '0;
                            op_d    = bus.Op;
                            state_d = EXEC;
                        end else begin
                            cnt_d = cnt_q + CNT_W'(1);
                        end
                    end
                end
                EXEC: begin
                    state_d = CAPTURE;
                end
                CAPTURE: begin
                    res_d   = bus.F;
                    zf_d    = bus.ZF;
                    of_d    = bus.OF;
                    done_d  = 1'b1;
                    state_d = SHOW;
                end
                SHOW: begin
                    // The strobe that leaves SHOW is a restart, its byte is dropped.
                    if (bus.Load) begin
                        state_d = LOAD_A;
                        aa_d    = '0;
                        bb_d    = '0;
                        done_d  = 1'b0;
                        cnt_d   = '0;
                    end
                end
                default: begin
                    state_d = LOAD_A;
                    aa_d    = '0;
                    bb_d    = '0;
                    res_d   = '0;
                    op_d    = '0;
                    zf_d    = 1'b0;
                    of_d    = 1'b0;
                    done_d  = 1'b0;
                    cnt_d   = '0;
                end
            endcase
        end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q <= LOAD_A;
            aa_q    <= '0;
            bb_q    <= '0;
            res_q   <= '0;
            op_q    <= '0;
            zf_q    <= 1'b0;
            of_q    <= 1'b0;
            done_q  <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            aa_q    <= aa_d;
            bb_q    <= bb_d;
            res_q   <= res_d;
            op_q    <= op_d;
            zf_q    <= zf_d;
            of_q    <= of_d;
            done_q  <= done_d;
            cnt_q   <= cnt_d;
        end
    end

    assign bus.AA     = aa_q;
    assign bus.BB     = bb_q;
    assign bus.ALU_OP = op_q;
    assign bus.Result = res_q;
    assign bus.ZF_Q   = zf_q;
    assign bus.OF_Q   = of_q;
    assign bus.Done   = done_q;
    assign bus.State  = state_q;
endmodule

// File: tb/tb_alu_operand_sequencer.sv
// Bench for alu_operand_sequencer: behavioural ALU plus transaction-level expectation model.
module tb_alu_operand_sequencer;
    localparam int DATA_W  = 32;
    localparam int CHUNK_W = 8;

    logic CLK   = 1'b0;
    logic RST_N = 1'b0;
    always #5 CLK = ~CLK;

    alu_operand_sequencer_if #(.DATA_W(DATA_W), .CHUNK_W(CHUNK_W)) bus ();

    alu_operand_sequencer #(.DATA_W(DATA_W), .CHUNK_W(CHUNK_W)) dut (
        .CLK   (CLK),
        .RST_N (RST_N),
        .bus   (bus)
    );

    int total = 0;
    int bad   = 0;

    // Expected architectural view of the sequencer.
    logic [31:0] exp_aa, exp_bb, exp_res;
    logic [2:0]  exp_op;
    logic        exp_zf, exp_of, exp_done;
    int          exp_state;

    // Returns {OF, ZF, F}.
    function automatic logic [33:0] alu_ref(input logic [31:0] a, input logic [31:0] b,
                                            input logic [2:0] op);
        logic [31:0] f;
        logic        ovf;
        ovf = 1'b0;
        case (op)
            3'd0: f = a & b;
            3'd1: f = a | b;
            3'd2: f = a ^ b;
            3'd3: f = ~(a | b);
            3'd4: begin f = a + b; ovf = (a[31] == b[31]) && (f[31] != a[31]); end
            3'd5: begin f = a - b; ovf = (a[31] != b[31]) && (f[31] != a[31]); end
            3'd6: f = b << a[4:0];
            default: f = {31'd0, ($signed(a) < $signed(b))};
        endcase
        return {ovf, (f == 32'd0), f};
    endfunction

    assign {bus.OF, bus.ZF, bus.F} = alu_ref(bus.AA, bus.BB, bus.ALU_OP);

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", tag, got, exp);
        end
    endtask

    task automatic check_all(input string tag);
        chk({tag, "_aa"},    64'(bus.AA),     64'(exp_aa));
        chk({tag, "_bb"},    64'(bus.BB),     64'(exp_bb));
        chk({tag, "_op"},    64'(bus.ALU_OP), 64'(exp_op));
        chk({tag, "_res"},   64'(bus.Result), 64'(exp_res));
        chk({tag, "_zf"},    64'(bus.ZF_Q),   64'(exp_zf));
        chk({tag, "_of"},    64'(bus.OF_Q),   64'(exp_of));
        chk({tag, "_done"},  64'(bus.Done),   64'(exp_done));
        chk({tag, "_state"}, 64'(bus.State),  64'(exp_state));
    endtask

    task automatic model_zero_all();
        exp_aa = '0; exp_bb = '0; exp_res = '0; exp_op = '0;
        exp_zf = 1'b0; exp_of = 1'b0; exp_done = 1'b0; exp_state = 0;
    endtask

    // Called at a negedge; returns at the negedge after the strobe edge.
    task automatic strobe(input logic [7:0] b);
        bus.Din  = b;
        bus.Load = 1'b1;
        @(negedge CLK);
        bus.Load = 1'b0;
    endtask

    task automatic leave_show(input string tag);
        strobe(8'($urandom));
        exp_state = 0; exp_aa = '0; exp_bb = '0; exp_done = 1'b0;
        check_all(tag);
    endtask

    task automatic load_word(input logic [31:0] w, input bit is_b, input logic [2:0] op,
                             input int maxgap, input string tag);
        for (int i = 0; i < 4; i++) begin
            repeat ($urandom_range(maxgap, 0)) @(negedge CLK);
            bus.Op = (is_b && i == 3) ? op : 3'($urandom);
            strobe(w[31 - 8*i -: 8]);
            if (is_b) exp_bb = w >> (8 * (3 - i));
            else      exp_aa = w >> (8 * (3 - i));
            if (i == 3) begin
                exp_state = is_b ? 2 : 1;
                if (is_b) exp_op = op;
            end
            check_all(tag);
        end
    endtask

    task automatic do_op(input logic [31:0] a, input logic [31:0] b, input logic [2:0] op,
                         input int maxgap, input bit disturb, input string tag);
        logic [33:0] r;
        if (exp_state == 4) leave_show({tag, "_leave"});
        load_word(a, 1'b0, 3'd0, maxgap, {tag, "_a"});
        load_word(b, 1'b1, op, maxgap, {tag, "_b"});
        if (disturb) begin
            bus.Din  = 8'($urandom);
            bus.Load = 1'b1;
        end
        @(negedge CLK);
        exp_state = 3;
        check_all({tag, "_cap"});
        @(negedge CLK);
        bus.Load = 1'b0;
        r = alu_ref(a, b, op);
        exp_res = r[31:0]; exp_zf = r[32]; exp_of = r[33];
        exp_done = 1'b1; exp_state = 4;
        check_all({tag, "_show"});
    endtask

    initial begin
        logic [31:0] ra, rb;
        bus.Din = '0; bus.Load = 1'b0; bus.Op = '0; bus.Clear = 1'b0;
        model_zero_all();
        #1;
        check_all("rst");
        repeat (2) @(negedge CLK);
        RST_N = 1'b1;
        @(negedge CLK);
        check_all("rst_rel");

        do_op(32'h12345678, 32'h00000008, 3'd4, 0, 1'b0, "t1");
        chk("t1_res_lit", 64'(bus.Result), 64'h12345680);
        chk("t1_done_lit", 64'(bus.Done), 64'd1);

        do_op(32'hDEADBEEF, 32'hDEADBEEF, 3'd5, 2, 1'b0, "t2");
        chk("t2_res_lit", 64'(bus.Result), 64'd0);
        chk("t2_zf_lit", 64'(bus.ZF_Q), 64'd1);

        do_op(32'h7FFFFFFF, 32'h00000001, 3'd4, 1, 1'b0, "t3");
        chk("t3_res_lit", 64'(bus.Result), 64'h80000000);
        chk("t3_of_lit", 64'(bus.OF_Q), 64'd1);

        // Partial A, then Clear with a coincident Load.
        leave_show("t4_leave");
        for (int i = 0; i < 3; i++) begin
            strobe(8'(8'h21 + i));
            exp_aa = (exp_aa << 8) | 32'(8'h21 + i);
            check_all("t4_part");
        end
        bus.Din = 8'hEE; bus.Load = 1'b1; bus.Clear = 1'b1;
        @(negedge CLK);
        bus.Load = 1'b0; bus.Clear = 1'b0;
        model_zero_all();
        check_all("t4_clr");
        do_op(32'hCAFEF00D, 32'h0F0F0F0F, 3'd2, 1, 1'b0, "t4_fresh");

        // Loads during EXEC/CAPTURE must not change the outcome.
        do_op(32'h01020304, 32'h10203040, 3'd4, 0, 1'b1, "t5");
        chk("t5_res_lit", 64'(bus.Result), 64'h11223344);
        leave_show("t5_leave");
        strobe(8'h5A);
        exp_aa = 32'h0000005A;
        check_all("t5_first");
        bus.Clear = 1'b1;
        @(negedge CLK);
        bus.Clear = 1'b0;
        model_zero_all();
        check_all("t5_clr");

        // Asynchronous reset in the middle of LOAD_B.
        do_op(32'hA5A5A5A5, 32'h5A5A5A5A, 3'd1, 0, 1'b0, "t6_pre");
        leave_show("t6_leave");
        load_word(32'h11111111, 1'b0, 3'd0, 0, "t6_a");
        strobe(8'h22);
        exp_bb = 32'h22;
        strobe(8'h33);
        exp_bb = 32'h2233;
        check_all("t6_partb");
        @(posedge CLK);
        #2 RST_N = 1'b0;
        #1;
        model_zero_all();
        check_all("t6_async");
        @(negedge CLK);
        RST_N = 1'b1;
        @(negedge CLK);
        check_all("t6_rel");
        do_op(32'h00000064, 32'h00000036, 3'd5, 1, 1'b0, "t6_post");

        for (int n = 0; n < 16; n++) begin
            case ($urandom_range(3, 0))
                0:       ra = 32'h7FFFFFFF;
                1:       ra = 32'h80000000;
                default: ra = $urandom;
            endcase
            rb = ($urandom_range(4, 0) == 0) ? ra : $urandom;
            do_op(ra, rb, 3'($urandom), 2, 1'($urandom), "rnd");
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
